// File: rtl/colortester_s_axi_regs.sv
// AXI4-Lite register bank for colortester: four 32-bit registers at 0x0..0xC.
// Define COLORTESTER_STATUS_RO_EN to make 0xC a read-only view of status_in.
module colortester_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  w_state_t w_state;
  w_state_t w_next;
  r_state_t r_state;
  r_state_t r_next;

  logic awready;
  logic wready;
  logic bvalid;
  logic arready;
  logic rvalid;
  logic awready_nxt;
  logic wready_nxt;
  logic bvalid_nxt;
  logic arready_nxt;
  logic rvalid_nxt;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;

  logic [1:0]    aw_sel_q;
  logic [DW-1:0] wdata_q;
  logic [NB-1:0] wstrb_q;

  logic          commit;
  logic          commit_ok;
  logic [1:0]    commit_sel;
  logic [DW-1:0] commit_data;
  logic [NB-1:0] commit_strb;

  logic [DW-1:0] regs [4];
  logic [DW-1:0] rdata;
  logic [DW-1:0] rdata_nxt;
  logic [DW-1:0] rd_word;
  logic [1:0]    aw_sel;
  logic [1:0]    ar_sel;

  assign aw_sel = S_AXI_AWADDR[AW-1:2];
  assign ar_sel = S_AXI_ARADDR[AW-1:2];

  assign aw_hs = S_AXI_AWVALID && awready;
  assign w_hs  = S_AXI_WVALID && wready;
  assign b_hs  = bvalid && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && arready;
  assign r_hs  = rvalid && S_AXI_RREADY;

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      w_state <= w_next;
      awready <= awready_nxt;
      wready  <= wready_nxt;
      bvalid  <= bvalid_nxt;
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_WAIT_DATA;
        else if (w_hs)     w_next = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (w_hs)  w_next = W_RESP;
      W_WAIT_ADDR: if (aw_hs) w_next = W_RESP;
      W_RESP:      if (b_hs)  w_next = W_IDLE;
      default:     w_next = W_IDLE;
    endcase
  end

  // Readies/valid are registered from the next state, so they stay low in reset.
  always_comb begin
    awready_nxt = (w_next == W_IDLE) || (w_next == W_WAIT_ADDR);
    wready_nxt  = (w_next == W_IDLE) || (w_next == W_WAIT_DATA);
    bvalid_nxt  = (w_next == W_RESP);
    commit      = 1'b0;
    commit_sel  = aw_sel_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    unique case (1'b1)
      (w_state == W_IDLE) && aw_hs && w_hs: begin
        commit      = 1'b1;
        commit_sel  = aw_sel;
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
      end
      (w_state == W_WAIT_DATA) && w_hs: begin
        commit      = 1'b1;
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
      end
      (w_state == W_WAIT_ADDR) && aw_hs: begin
        commit      = 1'b1;
        commit_sel  = aw_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_sel_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (w_state == W_IDLE) begin
      if (aw_hs) aw_sel_q <= aw_sel;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

`ifdef COLORTESTER_STATUS_RO_EN
  assign commit_ok = commit && (commit_sel != 2'd3);
`else
  assign commit_ok = commit;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      regs <= '{default: '0};
    end else if (commit_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (commit_strb[b])
          regs[commit_sel][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      r_state <= r_next;
      arready <= arready_nxt;
      rvalid  <= rvalid_nxt;
      rdata   <= rdata_nxt;
    end
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word = regs[ar_sel];
`ifdef COLORTESTER_STATUS_RO_EN
    if (ar_sel == 2'd3) rd_word = status_in;
`endif
    arready_nxt = (r_next == R_IDLE);
    rvalid_nxt  = (r_next == R_DATA);
    rdata_nxt   = rdata;
    if ((r_state == R_IDLE) && ar_hs) rdata_nxt = rd_word;
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;

  assign reg0_out = regs[0];
  assign reg1_out = regs[1];
  assign reg2_out = regs[2];
  assign reg3_out = regs[3];

  logic unused;
`ifdef COLORTESTER_STATUS_RO_EN
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                    status_in};
`endif

endmodule

// File: tb/tb_colortester_s_axi_regs.sv
// Directed bench for colortester_s_axi_regs: handshakes, strobes,
// back-pressure, mid-transaction reset and the optional read-only 0xC.
module tb_colortester_s_axi_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] status;
  logic [31:0] r0;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [31:0] r3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  colortester_s_axi_regs dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .status_in     (status),
    .reg0_out      (r0),
    .reg1_out      (r1),
    .reg2_out      (r2),
    .reg3_out      (r3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           input string tag);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      tick(); n++;
    end
    check({tag, "_rdy"}, 32'(awready && wready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      tick(); n++;
    end
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a,
                          input logic [31:0] exp,
                          input string tag);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick(); n++;
    end
    check({tag, "_arrdy"}, 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rresp"}, 32'(rresp), 32'd0);
    check({tag, "_rdata"}, rdata, exp);
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  logic [31:0] exp3;
  logic [31:0] exp3_out;
  int n;

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status = 32'h00C0FFEE;
`ifdef COLORTESTER_STATUS_RO_EN
    exp3 = 32'h00C0FFEE;
    exp3_out = 32'h0;
`else
    exp3 = 32'h4;
    exp3_out = 32'h4;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_regs", r0 | r1 | r2 | r3, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready", 32'(wready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);

    // Sequential writes then reads
    axi_write(4'h0, 32'h1, 4'hF, "w0");
    axi_write(4'h4, 32'h2, 4'hF, "w1");
    axi_write(4'h8, 32'h3, 4'hF, "w2");
    axi_write(4'hC, 32'h4, 4'hF, "w3");
    axi_read(4'h0, 32'h1, "r0");
    axi_read(4'h4, 32'h2, "r1");
    axi_read(4'h8, 32'h3, "r2");
    axi_read(4'hC, exp3, "r3");
    check("out0", r0, 32'h1);
    check("out1", r1, 32'h2);
    check("out2", r2, 32'h3);
    check("out3", r3, exp3_out);

    // W three cycles ahead of AW
    awaddr = 4'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin
      tick(); n++;
    end
    tick();
    wvalid = 1'b0;
    check("wfirst_wready", 32'(wready), 32'd0);
    check("wfirst_awready", 32'(awready), 32'd1);
    check("wfirst_nob", 32'(bvalid), 32'd0);
    check("wfirst_hold", r1, 32'h2);
    tick();
    tick();
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    check("wfirst_out1", r1, 32'hDEADBEEF);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(4'h4, 32'hDEADBEEF, "wfirst_rd");

    // Byte strobes
    axi_write(4'h8, 32'h11223344, 4'hF, "sfull");
    axi_write(4'h8, 32'hAABBCCDD, 4'b0101, "s0101");
    axi_read(4'h8, 32'h11BB33DD, "s0101_rd");
    axi_write(4'h8, 32'hFFFFFFFF, 4'b0000, "s0000");
    axi_read(4'h8, 32'h11BB33DD, "s0000_rd");

    // BREADY held low: response stable, no new write accepted
    axi_write(4'h0, 32'h0, 4'hF, "pre_bp");
    awaddr = 4'h0; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      tick(); n++;
    end
    tick();
    wdata = 32'h12121212;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_bresp", 32'(bresp), 32'd0);
      check("bp_ready", 32'({awready, wready}), 32'd0);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bp_bdone", 32'(bvalid), 32'd0);
    check("bp_out0", r0, 32'hA5A5A5A5);

    // RREADY held low: read data stable, no new AR accepted
    araddr = 4'h8; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick(); n++;
    end
    tick();
    araddr = 4'h0;
    for (int i = 0; i < 5; i++) begin
      check("rp_rvalid", 32'(rvalid), 32'd1);
      check("rp_rdata", rdata, 32'h11BB33DD);
      check("rp_arready", 32'(arready), 32'd0);
      tick();
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rp_rdone", 32'(rvalid), 32'd0);

    // Reset while waiting for write data
    axi_write(4'h4, 32'h55, 4'hF, "pre_rst");
    check("pre_rst_out1", r1, 32'h55);
    awaddr = 4'h4; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      tick(); n++;
    end
    tick();
    awvalid = 1'b0;
    check("wd_wready", 32'(wready), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mr_ready", 32'({awready, wready, arready}), 32'd0);
    check("mr_bvalid", 32'(bvalid), 32'd0);
    check("mr_regs", r0 | r1 | r2 | r3, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mr_rel_ready", 32'({awready, wready, arready}), 32'h7);
    check("mr_rel_bvalid", 32'(bvalid), 32'd0);
    axi_read(4'h4, 32'h0, "mr_rd1");

    // Register 3: read-only status view or ordinary register
    axi_write(4'hC, 32'h12345678, 4'hF, "w3b");
`ifdef COLORTESTER_STATUS_RO_EN
    axi_read(4'hC, 32'h00C0FFEE, "ro_rd3");
    check("ro_out3", r3, 32'h0);
`else
    axi_read(4'hC, 32'h12345678, "rw_rd3");
    check("rw_out3", r3, 32'h12345678);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
